// File: rtl/tpu_pkg.sv
// Shared constants and FSM encoding for the systolic array datapath blocks.
// The result drain and the operand feeder both import this package.
package tpu_pkg;

    localparam int unsigned TPU_DATA_WIDTH      = 16;
    localparam int unsigned TPU_SRAM_DATA_WIDTH = 32;
    localparam int unsigned TPU_ARRAY_LANES     = 4;
    localparam int unsigned TPU_ADDR_WIDTH      = 10;
    localparam int unsigned TPU_SETTLE          = 2;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StWrite,
        StDone
    } drain_state_e;

    // Number of SRAM words needed to hold one packed tile of lane results.
    function automatic int unsigned words_per_tile(input int unsigned lanes,
                                                   input int unsigned data_width,
                                                   input int unsigned sram_width);
        return (lanes * data_width) / sram_width;
    endfunction

endpackage

// File: rtl/edge_fall_detect.sv
// Registers a level signal and flags its falling edge (registered 1, current 0).
// Shared by the result drain and the operand feeder to watch systolic_en.
module edge_fall_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic fall_o
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign fall_o = sig_q & ~sig_i;

endmodule

// File: rtl/systolic_drain.sv
// Collects packed lane results when the systolic compute window closes and streams
// them to result SRAM as consecutive words at an auto-incrementing address.
module systolic_drain
    import tpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = TPU_DATA_WIDTH,
    parameter int unsigned LANES           = TPU_ARRAY_LANES,
    parameter int unsigned SRAM_DATA_WIDTH = TPU_SRAM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH      = TPU_ADDR_WIDTH,
    parameter int unsigned SETTLE          = TPU_SETTLE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          systolic_en,
    input  logic [LANES*DATA_WIDTH-1:0]   data_in,
    input  logic                          cfg_load,
    input  logic [ADDR_WIDTH-1:0]         cfg_base,
    output logic                          sram_wr,
    output logic [ADDR_WIDTH-1:0]         sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0]    sram_wdata,
    input  logic                          sram_ready,
    output logic                          busy,
    output logic                          tile_done,
    output logic [7:0]                    tile_count,
    output logic                          overrun
);

    localparam int unsigned WPT  = words_per_tile(LANES, DATA_WIDTH, SRAM_DATA_WIDTH);
    localparam int unsigned IdxW = (WPT > 1) ? $clog2(WPT) : 1;
    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    drain_state_e                          state_q;
    logic [CntW-1:0]                       cnt_q;
    logic [ADDR_WIDTH-1:0]                 wr_ptr_q;
    logic [IdxW-1:0]                       word_idx_q;
    logic [WPT-1:0][SRAM_DATA_WIDTH-1:0]   buf_q;
    logic                                  sram_wr_q;
    logic [ADDR_WIDTH-1:0]                 sram_addr_q;
    logic [SRAM_DATA_WIDTH-1:0]            sram_wdata_q;
    logic                                  tile_done_q;
    logic [7:0]                            tile_count_q;
    logic                                  overrun_q;

    logic                                  fall;
    logic [IdxW-1:0]                       next_idx;
    logic [ADDR_WIDTH-1:0]                 next_ptr;
    logic                                  last_word;

    edge_fall_detect u_en_fall (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (systolic_en),
        .fall_o (fall)
    );

    assign next_idx  = word_idx_q + 1'b1;
    assign next_ptr  = wr_ptr_q + 1'b1;
    assign last_word = (word_idx_q == IdxW'(WPT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            word_idx_q   <= '0;
            buf_q        <= '0;
            sram_wr_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            tile_done_q  <= 1'b0;
            tile_count_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            tile_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cfg_load) begin
                        wr_ptr_q  <= cfg_base;
                        overrun_q <= 1'b0;
                    end
                    if (fall) begin
                        cnt_q   <= CntW'(SETTLE - 1);
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (fall) overrun_q <= 1'b1;
                    // Capture once the array pipeline has flushed its last results.
                    if (cnt_q == '0) begin
                        buf_q        <= data_in;
                        word_idx_q   <= '0;
                        sram_wr_q    <= 1'b1;
                        sram_addr_q  <= wr_ptr_q;
                        sram_wdata_q <= data_in[SRAM_DATA_WIDTH-1:0];
                        state_q      <= StWrite;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StWrite: begin
                    if (fall) overrun_q <= 1'b1;
                    // sram_wr is high for the whole of this state, so ready alone means accept.
                    if (sram_ready) begin
                        wr_ptr_q   <= next_ptr;
                        word_idx_q <= next_idx;
                        if (last_word) begin
                            sram_wr_q   <= 1'b0;
                            tile_done_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            sram_addr_q  <= next_ptr;
                            sram_wdata_q <= buf_q[next_idx];
                        end
                    end
                end
                StDone: begin
                    if (fall) overrun_q <= 1'b1;
                    tile_count_q <= tile_count_q + 8'd1;
                    state_q      <= StIdle;
                end
                default: begin
                    sram_wr_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign busy       = (state_q != StIdle);
    assign sram_wr    = sram_wr_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign tile_done  = tile_done_q;
    assign tile_count = tile_count_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: directed tiles plus randomized traffic, all checked
// against a queue-based model of the expected SRAM write stream.
module tb_systolic_drain;

    localparam int SETTLE = 2;
    localparam int WPT    = 2;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        systolic_en = 1'b0;
    logic [63:0] data_in = '0;
    logic        cfg_load = 1'b0;
    logic [9:0]  cfg_base = '0;
    logic        sram_wr;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_ready = 1'b1;
    logic        busy;
    logic        tile_done;
    logic [7:0]  tile_count;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: pending writes in order, plus tile bookkeeping.
    wr_t        pend[$];
    logic       m_en_d;
    logic       m_active;
    logic       m_done;
    logic [9:0] m_ptr;
    logic [7:0] m_count;
    logic       m_ovr;
    int         m_cap;
    int         edge_n;
    int         n_acc;

    always #5 clk = ~clk;

    systolic_drain dut (
        .clk         (clk),
        .rst         (rst),
        .systolic_en (systolic_en),
        .data_in     (data_in),
        .cfg_load    (cfg_load),
        .cfg_base    (cfg_base),
        .sram_wr     (sram_wr),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_ready  (sram_ready),
        .busy        (busy),
        .tile_done   (tile_done),
        .tile_count  (tile_count),
        .overrun     (overrun)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_en_d   = 1'b0;
        m_active = 1'b0;
        m_done   = 1'b0;
        m_ptr    = '0;
        m_count  = '0;
        m_ovr    = 1'b0;
        m_cap    = -1;
    endtask

    // Applies the effect of one rising edge given the inputs held across it.
    task automatic model_edge();
        logic fall, was_active, acc;
        if (!rst) begin
            model_reset();
            return;
        end
        edge_n++;
        fall       = m_en_d && !systolic_en;
        m_en_d     = systolic_en;
        was_active = m_active;
        acc        = (pend.size() > 0) && sram_ready;
        if (m_done) begin
            m_done   = 1'b0;
            m_active = 1'b0;
            m_count  = m_count + 8'd1;
        end
        if (!was_active) begin
            if (cfg_load) begin
                m_ptr = cfg_base;
                m_ovr = 1'b0;
            end
            if (fall) begin
                m_active = 1'b1;
                m_cap    = edge_n + SETTLE;
            end
        end else if (fall) begin
            m_ovr = 1'b1;
        end
        if (acc) begin
            void'(pend.pop_front());
            n_acc++;
            if (pend.size() == 0) m_done = 1'b1;
        end
        if (was_active && edge_n == m_cap) begin
            for (int k = 0; k < WPT; k++) begin
                pend.push_back('{addr: m_ptr, data: data_in[k*32 +: 32]});
                m_ptr = m_ptr + 10'd1;
            end
        end
    endtask

    task automatic compare();
        check_eq("sram_wr", sram_wr, pend.size() > 0);
        if (pend.size() > 0) begin
            check_eq("sram_addr", sram_addr, pend[0].addr);
            check_eq("sram_wdata", sram_wdata, pend[0].data);
        end
        check_eq("tile_done", tile_done, m_done);
        check_eq("busy", busy, m_active);
        check_eq("tile_count", tile_count, m_count);
        check_eq("overrun", overrun, m_ovr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Leaves the bench at the falling clock edge just after the fall-detect edge T.
    task automatic window(input int n);
        systolic_en = 1'b1;
        repeat (n) tick();
        systolic_en = 1'b0;
        tick();
    endtask

    task automatic load_base(input logic [9:0] base);
        cfg_base = base;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic tile_ready(input string tag, input int len, input logic [9:0] a0,
                              input logic [63:0] d);
        logic [9:0] a1;
        a1         = a0 + 10'd1;
        data_in    = d;
        sram_ready = 1'b1;
        window(len);
        tick();
        tick();
        check_eq({tag, "_a0"}, sram_addr, a0);
        check_eq({tag, "_d0"}, sram_wdata, d[31:0]);
        tick();
        check_eq({tag, "_a1"}, sram_addr, a1);
        check_eq({tag, "_d1"}, sram_wdata, d[63:32]);
        tick();
        check_eq({tag, "_done"}, tile_done, 1'b1);
        tick();
    endtask

    initial begin
        int acc0;
        logic [7:0] cnt0;
        model_reset();
        edge_n = 0;
        n_acc  = 0;

        rst = 1'b0;
        idle(2);
        check_eq("rst_wr", sram_wr, 1'b0);
        check_eq("rst_addr", sram_addr, 10'h000);
        check_eq("rst_wdata", sram_wdata, 32'h0);
        check_eq("rst_cnt", tile_count, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Basic tile, then a back-to-back tile continuing the address stream.
        load_base(10'h010);
        tile_ready("basic", 10, 10'h010, 64'h0004_0003_0002_0001);
        check_eq("basic_count", tile_count, 8'd1);
        check_eq("basic_busy", busy, 1'b0);

        // Backpressure on word0 for three cycles.
        data_in = 64'h0004_0003_0002_0001;
        window(10);
        tick();
        tick();
        sram_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_hold_wr", sram_wr, 1'b1);
            check_eq("bp_hold_addr", sram_addr, 10'h012);
            check_eq("bp_hold_data", sram_wdata, 32'h0002_0001);
        end
        sram_ready = 1'b1;
        tick();
        check_eq("bp_w1_addr", sram_addr, 10'h013);
        tick();
        check_eq("bp_done", tile_done, 1'b1);
        tick();

        // Address wrap at the top of the SRAM.
        load_base(10'h3FF);
        tile_ready("wrap", 4, 10'h3FF, {$urandom, $urandom});
        idle(2);
        tile_ready("wrap_next", 4, 10'h001, {$urandom, $urandom});

        // Capture happens SETTLE edges after the fall, not at the fall itself.
        data_in = 64'hAAAA_AAAA_AAAA_AAAA;
        window(5);
        data_in = 64'h5555_5555_5555_5555;
        tick();
        tick();
        check_eq("settle_d0", sram_wdata, 32'h5555_5555);
        tick();
        check_eq("settle_d1", sram_wdata, 32'h5555_5555);
        idle(3);

        // Second window closing during WRITE raises overrun and is dropped.
        acc0 = n_acc;
        cnt0 = tile_count;
        data_in = {$urandom, $urandom};
        sram_ready = 1'b0;
        window(5);
        tick();
        tick();
        systolic_en = 1'b1;
        tick();
        systolic_en = 1'b0;
        tick();
        check_eq("ovr_set", overrun, 1'b1);
        sram_ready = 1'b1;
        idle(6);
        check_eq("ovr_writes", n_acc - acc0, 2);
        check_eq("ovr_count", tile_count, cnt0 + 8'd1);
        check_eq("ovr_sticky", overrun, 1'b1);
        load_base(10'h040);
        check_eq("ovr_clear", overrun, 1'b0);

        // Asynchronous reset in the middle of a tile.
        data_in = {$urandom, $urandom};
        window(4);
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        model_reset();
        check_eq("mid_rst_wr", sram_wr, 1'b0);
        check_eq("mid_rst_addr", sram_addr, 10'h000);
        check_eq("mid_rst_wdata", sram_wdata, 32'h0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_cnt", tile_count, 8'h00);
        tick();
        rst = 1'b1;
        idle(8);
        tile_ready("post_rst", 3, 10'h000, {$urandom, $urandom});

        // Randomized traffic: windows of varying length, backpressure, reloads.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) systolic_en = ~systolic_en;
            sram_ready = ($urandom_range(0, 3) != 0);
            cfg_load   = ($urandom_range(0, 9) == 0);
            cfg_base   = 10'($urandom);
            data_in    = {$urandom, $urandom};
            tick();
        end
        cfg_load    = 1'b0;
        systolic_en = 1'b0;
        sram_ready  = 1'b1;
        idle(10);
        check_eq("final_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
